// File: rtl/ps2mouse_pkg.sv
// rtl/ps2mouse_pkg.sv - shared constants, FSM encoding and packet decode for ps2mouse_position
package ps2mouse_pkg;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  localparam logic [7:0] ERR_MAX = 8'd255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SUM    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  // Only the fields the datapath needs are kept once a packet is accepted.
  typedef struct packed {
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
  } motion_t;

  function automatic motion_t to_motion(logic [23:0] pkt);
    motion_t m;
    m.btn = {pkt[BTN_M], pkt[BTN_R], pkt[BTN_L]};
    m.dx  = {pkt[XS], pkt[15:8]};
    m.dy  = {pkt[YS], pkt[23:16]};
    return m;
  endfunction

endpackage

// File: rtl/ps2mouse_if.sv
// rtl/ps2mouse_if.sv - packet input and cursor output bundle for ps2mouse_position
interface ps2mouse_if #(
  parameter int POS_W = 10
);
  logic             iTrig;
  logic [23:0]      iData;
  logic             iRecenter;
  logic [POS_W-1:0] oX;
  logic [POS_W-1:0] oY;
  logic [2:0]       oBtn;
  logic             oTrig;
  logic [7:0]       oErrCnt;

  modport master (
    output iTrig, iData, iRecenter,
    input  oX, oY, oBtn, oTrig, oErrCnt
  );

  modport slave (
    input  iTrig, iData, iRecenter,
    output oX, oY, oBtn, oTrig, oErrCnt
  );
endinterface

// File: rtl/ps2mouse_position_axis.sv
// rtl/ps2mouse_position_axis.sv - one cursor axis: signed accumulate, clamp to [0, MAX], recenter
module ps2mouse_axis #(
  parameter int MAX  = 639,
  parameter int INIT = 320,
  parameter int W    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              recenter,
  input  logic              sum_en,
  input  logic              commit_en,
  input  logic signed [9:0] delta,
  output logic [W-1:0]      pos
);

  localparam logic signed [W+1:0] MAX_S = (W+2)'(MAX);

  logic signed [W+1:0] sum_q;
  logic signed [W+1:0] delta_ext;
  logic [W-1:0]        clamped;

  assign delta_ext = (W+2)'(delta);

  // Saturate the unclamped sum into the screen window.
  always_comb begin
    clamped = sum_q[W-1:0];
    if (sum_q < 0) begin
      clamped = '0;
    end else if (sum_q > MAX_S) begin
      clamped = W'(MAX);
    end
  end

  // Sum in the SUM state, publish the clamped value in COMMIT; recenter wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos   <= W'(INIT);
      sum_q <= '0;
    end else if (recenter) begin
      pos <= W'(INIT);
    end else begin
      if (sum_en) begin
        sum_q <= $signed({2'b00, pos}) + delta_ext;
      end
      if (commit_en) begin
        pos <= clamped;
      end
    end
  end

endmodule

// File: rtl/ps2mouse_position.sv
// rtl/ps2mouse_position.sv - relative PS/2 packets to clamped absolute cursor (option: PS2MOUSE_OVF_DROP_EN)
module ps2mouse_position
  import ps2mouse_pkg::*;
#(
  parameter int X_MAX  = 639,
  parameter int Y_MAX  = 479,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int POS_W  = 10
) (
  input logic       CLOCK,
  input logic       RST_n,
  ps2mouse_if.slave bus
);

  state_t  state_q, state_d;
  motion_t work_q, pend_q;
  logic    pend_valid_q;
  logic [2:0] btn_q;
  logic       trig_q;
  logic [7:0] err_q;

  logic pkt_ok, trig_ok, err_inc;
  logic load_work_new, load_work_pend, load_pend, clr_pend, drop;
  logic sum_en, commit_en;
  logic signed [9:0] dx_ext, dy_neg;

  // A packet is usable only with the sync bit set (and, optionally, no overflow).
  always_comb begin
`ifdef PS2MOUSE_OVF_DROP_EN
    pkt_ok = bus.iData[SYNC] & ~bus.iData[XO] & ~bus.iData[YO];
`else
    pkt_ok = bus.iData[SYNC];
`endif
  end

  assign trig_ok = bus.iTrig & pkt_ok & ~bus.iRecenter;
  assign err_inc = (bus.iTrig & ~bus.iRecenter & ~pkt_ok) | drop;

  // Next state plus intake routing between working register and pending slot.
  always_comb begin
    state_d        = state_q;
    load_work_new  = 1'b0;
    load_work_pend = 1'b0;
    load_pend      = 1'b0;
    clr_pend       = 1'b0;
    drop           = 1'b0;
    sum_en         = 1'b0;
    commit_en      = 1'b0;
    if (bus.iRecenter) begin
      state_d  = IDLE;
      clr_pend = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pend_valid_q) begin
            load_work_pend = 1'b1;
            clr_pend       = 1'b1;
            load_pend      = trig_ok;
            state_d        = SUM;
          end else if (trig_ok) begin
            load_work_new = 1'b1;
            state_d       = SUM;
          end
        end
        SUM: begin
          sum_en    = 1'b1;
          state_d   = COMMIT;
          load_pend = trig_ok & ~pend_valid_q;
          drop      = trig_ok & pend_valid_q;
        end
        COMMIT: begin
          commit_en = 1'b1;
          load_pend = trig_ok & ~pend_valid_q;
          drop      = trig_ok & pend_valid_q;
          if (pend_valid_q) begin
            load_work_pend = 1'b1;
            clr_pend       = 1'b1;
            state_d        = SUM;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Working register and one-deep pending buffer.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      work_q       <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
    end else begin
      if (load_work_new) begin
        work_q <= to_motion(bus.iData);
      end else if (load_work_pend) begin
        work_q <= pend_q;
      end
      if (load_pend) begin
        pend_q       <= to_motion(bus.iData);
        pend_valid_q <= 1'b1;
      end else if (clr_pend) begin
        pend_valid_q <= 1'b0;
      end
    end
  end

  // Buttons, update strobe and saturating error counter.
  always_ff @(posedge CLOCK or negedge RST_n) begin
    if (!RST_n) begin
      btn_q  <= 3'b000;
      trig_q <= 1'b0;
      err_q  <= 8'd0;
    end else begin
      trig_q <= bus.iRecenter | commit_en;
      if (commit_en) begin
        btn_q <= work_q.btn;
      end
      if (err_inc && err_q != ERR_MAX) begin
        err_q <= err_q + 8'd1;
      end
    end
  end

  // PS/2 reports up as positive; the screen Y axis grows downward.
  assign dx_ext = {work_q.dx[8], work_q.dx};
  assign dy_neg = 10'sd0 - $signed({work_q.dy[8], work_q.dy});

  ps2mouse_axis #(.MAX(X_MAX), .INIT(X_INIT), .W(POS_W)) u_x (
    .clk       (CLOCK),
    .rst_n     (RST_n),
    .recenter  (bus.iRecenter),
    .sum_en    (sum_en),
    .commit_en (commit_en),
    .delta     (dx_ext),
    .pos       (bus.oX)
  );

  ps2mouse_axis #(.MAX(Y_MAX), .INIT(Y_INIT), .W(POS_W)) u_y (
    .clk       (CLOCK),
    .rst_n     (RST_n),
    .recenter  (bus.iRecenter),
    .sum_en    (sum_en),
    .commit_en (commit_en),
    .delta     (dy_neg),
    .pos       (bus.oY)
  );

  assign bus.oBtn    = btn_q;
  assign bus.oTrig   = trig_q;
  assign bus.oErrCnt = err_q;

endmodule

// File: tb/tb_ps2mouse_position.sv
// tb/tb_ps2mouse_position.sv - self-checking bench for ps2mouse_position with packet-level model
module tb_ps2mouse_position;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2mouse_if #(.POS_W(10)) bus ();

  ps2mouse_position #(
    .X_MAX(639), .Y_MAX(479), .X_INIT(320), .Y_INIT(240), .POS_W(10)
  ) dut (
    .CLOCK (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: cursor, buttons, error count.
  int m_x, m_y, m_btn, m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int clampi(int v, int mx);
    if (v < 0) return 0;
    if (v > mx) return mx;
    return v;
  endfunction

  function automatic bit model_accept(logic [23:0] p);
`ifdef PS2MOUSE_OVF_DROP_EN
    return p[3] && !p[6] && !p[7];
`else
    return p[3];
`endif
  endfunction

  task automatic model_apply(input logic [23:0] p);
    int dx, dy;
    dx = int'(p[15:8]) - (p[4] ? 256 : 0);
    dy = int'(p[23:16]) - (p[5] ? 256 : 0);
    m_x   = clampi(m_x + dx, 639);
    m_y   = clampi(m_y - dy, 479);
    m_btn = int'(p[2:0]);
  endtask

  task automatic model_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 240; m_btn = 0; m_err = 0;
  endtask

  task automatic check_state(input string tag);
    check({tag, ".x"},   32'(bus.oX),      32'(m_x));
    check({tag, ".y"},   32'(bus.oY),      32'(m_y));
    check({tag, ".btn"}, 32'(bus.oBtn),    32'(m_btn));
    check({tag, ".err"}, 32'(bus.oErrCnt), 32'(m_err));
  endtask

  // Single isolated packet; the update must land exactly three edges after iTrig is presented.
  task automatic send(input logic [23:0] p, input string tag);
    bit acc;
    int early;
    acc = model_accept(p);
    bus.iData = p;
    bus.iTrig = 1'b1;
    tick();
    bus.iTrig = 1'b0;
    early = int'(bus.oTrig);
    tick();
    early += int'(bus.oTrig);
    tick();
    if (acc) model_apply(p);
    else model_err();
    check({tag, ".early"}, 32'(early), 32'd0);
    check({tag, ".trig"}, 32'(bus.oTrig), 32'(acc));
    check_state(tag);
    tick();
    check({tag, ".trig_low"}, 32'(bus.oTrig), 32'd0);
  endtask

  task automatic recenter(input string tag);
    bus.iRecenter = 1'b1;
    tick();
    bus.iRecenter = 1'b0;
    m_x = 320; m_y = 240;
    check({tag, ".trig"}, 32'(bus.oTrig), 32'd1);
    check_state(tag);
    tick();
    check({tag, ".trig_low"}, 32'(bus.oTrig), 32'd0);
  endtask

  initial begin
    int pulses;
    logic [23:0] p;
    bus.iTrig = 1'b0;
    bus.iData = 24'h0;
    bus.iRecenter = 1'b0;
    model_reset();

    repeat (3) tick();
    check("reset.trig", 32'(bus.oTrig), 32'd0);
    check_state("reset");
    rst_n = 1'b1;
    tick();

    // Basic motion, Y sign handling, buttons.
    send(24'h000508, "dx5");
    check("dx5.abs", 32'(bus.oX), 32'd325);
    send(24'hF60028, "dym10");
    check("dym10.abs", 32'(bus.oY), 32'd250);
    send(24'h000009, "btnL");
    check("btnL.abs", 32'(bus.oBtn), 32'd1);

    // Clamp at both X limits.
    for (int i = 0; i < 3; i++) send(24'h007F08, "xplus");
    check("xmax.abs", 32'(bus.oX), 32'd639);
    recenter("rc1");
    send(24'h008018, "xm128a");
    send(24'h008018, "xm128b");
    send(24'h00F218, "xm14");
    check("x50.abs", 32'(bus.oX), 32'd50);
    send(24'h008018, "xm128c");
    check("xmin.abs", 32'(bus.oX), 32'd0);

    // Sync errors and counter saturation.
    send(24'h000000, "sync");
    check("sync.err", 32'(bus.oErrCnt), 32'd1);
    bus.iData = 24'h000000;
    bus.iTrig = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      model_err();
    end
    bus.iTrig = 1'b0;
    tick();
    check("errsat", 32'(bus.oErrCnt), 32'd255);
    check_state("errsat");

    // Asynchronous reset mid-run.
    rst_n = 1'b0;
    #1;
    model_reset();
    check("areset.trig", 32'(bus.oTrig), 32'd0);
    check_state("areset");
    tick();
    rst_n = 1'b1;
    tick();

    // Back-to-back packets: two absorbed, third dropped.
    bus.iData = 24'h000108;
    bus.iTrig = 1'b1;
    repeat (3) tick();
    bus.iTrig = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      pulses += int'(bus.oTrig);
      tick();
    end
    model_apply(24'h000108);
    model_apply(24'h000108);
    model_err();
    check("burst.pulses", 32'(pulses), 32'd2);
    check_state("burst");
    check("burst.x", 32'(bus.oX), 32'd322);

    // Recenter colliding with a packet at X = 600.
    send(24'h007E08, "to600a");
    send(24'h007E08, "to600b");
    send(24'h001A08, "to600c");
    check("x600", 32'(bus.oX), 32'd600);
    bus.iData = 24'h000508;
    bus.iTrig = 1'b1;
    bus.iRecenter = 1'b1;
    tick();
    bus.iTrig = 1'b0;
    bus.iRecenter = 1'b0;
    pulses = int'(bus.oTrig);
    for (int i = 0; i < 6; i++) begin
      tick();
      pulses += int'(bus.oTrig);
    end
    m_x = 320; m_y = 240;
    check("rc_trig.pulses", 32'(pulses), 32'd1);
    check_state("rc_trig");

    // Overflow-flagged packet: rejected only when the drop option is built in.
    send(24'h000148, "ovf");

    // Randomized packets against the model.
    for (int i = 0; i < 40; i++) begin
      p = 24'($urandom);
      p[3] = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) != 0) p[7:6] = 2'b00;
      if ($urandom_range(0, 9) == 0) recenter("rnd_rc");
      send(p, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
